// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared prescaler and period counter.
// Edge- or center-aligned; duty and mode changes take effect at period boundaries.
module pwm_multi #(
  parameter int R          = 8,
  parameter int CH         = 4,
  parameter int TIMER_BITS = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [TIMER_BITS-1:0] FINAL_VALUE,
  input  logic [CH*(R+1)-1:0]   duty,
  input  logic [CH-1:0]         polarity,
  input  logic                  center_mode,
  input  logic                  load,
  output logic [CH-1:0]         pwm_out,
  output logic                  period_done
);

  localparam int DW = R + 1;
  localparam logic [R-1:0] MAX = '1;
  localparam logic [R-1:0] Q_ONE = R'(1);
  localparam logic [TIMER_BITS-1:0] P_ONE = TIMER_BITS'(1);

  typedef enum logic {UP, DOWN} state_t;

  logic [TIMER_BITS-1:0] r_presc;
  logic [R-1:0]          r_q;
  state_t                r_state;
  logic [CH*DW-1:0]      r_pend_duty;
  logic [CH*DW-1:0]      r_act_duty;
  logic                  r_pend_mode;
  logic                  r_act_mode;

  logic                  w_tick;
  logic                  w_edge_bnd;
  logic                  w_ctr_bnd;
  logic                  w_boundary;
  logic                  w_mode_chg;
  logic [CH-1:0]         w_cmp;

  assign w_tick = enable && (r_presc == FINAL_VALUE);

  assign w_edge_bnd = !r_act_mode && (r_q == MAX);
  assign w_ctr_bnd  = r_act_mode && (r_state == DOWN)
                   && (r_q == '0);

  assign w_boundary  = w_tick && (w_edge_bnd || w_ctr_bnd);
  assign w_mode_chg  = r_pend_mode != r_act_mode;
  assign period_done = w_boundary;

  // A count above a freshly lowered FINAL_VALUE runs on through wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (!enable || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + P_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= '0;
      r_state <= UP;
    end else if (!enable) begin
      r_q     <= '0;
      r_state <= UP;
    end else if (w_tick) begin
      if (w_boundary && w_mode_chg) begin
        r_q     <= '0;
        r_state <= UP;
      end else if (!r_act_mode) begin
        r_q     <= r_q + Q_ONE;
        r_state <= UP;
      end else begin
        unique case (r_state)
          UP: begin
            if (r_q == MAX) begin
              r_q     <= MAX - Q_ONE;
              r_state <= DOWN;
            end else begin
              r_q <= r_q + Q_ONE;
            end
          end
          DOWN: begin
            if (r_q == '0) begin
              r_q     <= Q_ONE;
              r_state <= UP;
            end else begin
              r_q <= r_q - Q_ONE;
            end
          end
        endcase
      end
    end
  end

  // Old pending values move to active, so a load on the boundary waits a period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend_duty <= '0;
      r_pend_mode <= 1'b0;
      r_act_duty  <= '0;
      r_act_mode  <= 1'b0;
    end else begin
      if (load) begin
        r_pend_duty <= duty;
        r_pend_mode <= center_mode;
      end
      if (!enable || w_boundary) begin
        r_act_duty <= r_pend_duty;
        r_act_mode <= r_pend_mode;
      end
    end
  end

  always_comb begin
    w_cmp = '0;
    for (int k = 0; k < CH; k++) begin
      w_cmp[k] = {1'b0, r_q} < r_act_duty[k*DW +: DW];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_out <= '0;
    end else if (!enable) begin
      pwm_out <= polarity;
    end else if (w_tick) begin
      pwm_out <= w_cmp ^ polarity;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: phase-based reference model, duty table,
// directed corner sequences and randomized traffic.
module tb_pwm_multi;

  localparam int R   = 4;
  localparam int CH  = 4;
  localparam int TB  = 15;
  localparam int DW  = R + 1;
  localparam int MX  = (1 << R) - 1;
  localparam int PE  = 1 << R;
  localparam int PC  = 2 * MX;
  localparam int PMOD = 1 << TB;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [TB-1:0]     FINAL_VALUE = '0;
  logic [CH*DW-1:0]  duty = '0;
  logic [CH-1:0]     polarity = 4'hF;
  logic              center_mode = 1'b0;
  logic              load = 1'b0;
  logic [CH-1:0]     pwm_out;
  logic              period_done;

  pwm_multi #(.R(R), .CH(CH), .TIMER_BITS(TB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .FINAL_VALUE(FINAL_VALUE),
    .duty(duty),
    .polarity(polarity),
    .center_mode(center_mode),
    .load(load),
    .pwm_out(pwm_out),
    .period_done(period_done)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: prescaler count, ticks since counting restarted, duty sets.
  int          m_presc;
  int          m_n;
  int          m_act[CH];
  int          m_pend[CH];
  bit          m_act_mode;
  bit          m_pend_mode;
  logic [CH-1:0] m_pwm;
  bit          last_done;

  typedef struct packed {
    logic          mode;
    logic [19:0]   d;
    logic [3:0]    pol;
    logic [7:0]    per;
    logic [31:0]   cnt;
  } vec_t;

  vec_t vecs[5];

  function automatic void chk(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  function automatic int qof(int n, bit c);
    int p;
    if (!c) return n % PE;
    p = n % PC;
    return (p <= MX) ? p : PC - p;
  endfunction

  function automatic bit bnd(int n, bit c);
    if (!c) return (n % PE) == MX;
    return (n > 0) && ((n % PC) == 0);
  endfunction

  function automatic logic [19:0] pk(int a, int b, int c, int e);
    return {5'(e), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic logic [31:0] ck(int a, int b, int c, int e);
    return {8'(e), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic model_reset();
    m_presc = 0;
    m_n = 0;
    for (int k = 0; k < CH; k++) begin
      m_act[k] = 0;
      m_pend[k] = 0;
    end
    m_act_mode = 0;
    m_pend_mode = 0;
    m_pwm = '0;
  endtask

  task automatic step();
    bit tick;
    bit done;
    int q;
    @(negedge clk);
    tick = reset_n && enable && (m_presc == int'(FINAL_VALUE));
    done = tick && bnd(m_n, m_act_mode);
    chk("period_done", period_done, done);
    last_done = done;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else if (!enable) begin
      m_presc = 0;
      m_n = 0;
      m_pwm = polarity;
      m_act = m_pend;
      m_act_mode = m_pend_mode;
    end else if (tick) begin
      q = qof(m_n, m_act_mode);
      for (int k = 0; k < CH; k++)
        m_pwm[k] = (q < m_act[k]) ^ polarity[k];
      if (done) begin
        m_n = (m_pend_mode != m_act_mode) ? 0 : m_n + 1;
        m_act = m_pend;
        m_act_mode = m_pend_mode;
      end else begin
        m_n++;
      end
      m_presc = 0;
    end else begin
      m_presc = (m_presc + 1) % PMOD;
    end
    if (reset_n && load) begin
      for (int k = 0; k < CH; k++)
        m_pend[k] = int'(duty[k*DW +: DW]);
      m_pend_mode = center_mode;
    end
    #1;
    chk("pwm_out", pwm_out, m_pwm);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (last_done) begin
        ok = 1;
        break;
      end
    end
    chk("wait_done_timeout", ok, 1);
  endtask

  task automatic steps_to_done(input string name, input int exp);
    int got;
    got = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (last_done) begin
        got = i;
        break;
      end
    end
    chk(name, got, exp);
  endtask

  task automatic count_ch0(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step();
      c += int'(pwm_out[0]);
    end
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_done", period_done, 0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt[CH];
    int got_len;
    int c;
    int toggles;
    logic [CH-1:0] prev;

    vecs[0] = '{1'b0, pk(4, 0, 16, 9), 4'b0000, 8'd16, ck(4, 0, 16, 9)};
    vecs[1] = '{1'b0, pk(0, 16, 3, 15), 4'b0010, 8'd16, ck(0, 16, 3, 15)};
    vecs[2] = '{1'b1, pk(5, 0, 16, 8), 4'b0000, 8'd30, ck(9, 0, 30, 15)};
    vecs[3] = '{1'b1, pk(1, 31, 2, 14), 4'b1111, 8'd30, ck(1, 30, 3, 27)};
    vecs[4] = '{1'b0, pk(1, 31, 8, 12), 4'b0101, 8'd16, ck(1, 16, 8, 12)};

    model_reset();
    last_done = 0;
    step();
    step();
    chk("in_reset_pwm", pwm_out, 0);
    reset_n = 1'b1;
    enable = 1'b1;
    step();
    chk("post_reset_inactive", pwm_out, 4'hF);

    foreach (vecs[v]) begin
      polarity = vecs[v].pol;
      center_mode = vecs[v].mode;
      duty = vecs[v].d;
      pulse_load();
      wait_done(200);
      wait_done(200);
      got_len = 0;
      for (int k = 0; k < CH; k++) cnt[k] = 0;
      for (int i = 1; i <= int'(vecs[v].per); i++) begin
        step();
        for (int k = 0; k < CH; k++)
          cnt[k] += int'(pwm_out[k] ^ vecs[v].pol[k]);
        if (last_done && got_len == 0) got_len = i;
      end
      chk("period_len", got_len, int'(vecs[v].per));
      for (int k = 0; k < CH; k++)
        chk("active_count", cnt[k], int'(vecs[v].cnt[k*8 +: 8]));
    end

    // Mid-period reload keeps the running period intact.
    polarity = '0;
    center_mode = 1'b0;
    duty = pk(3, 0, 0, 0);
    pulse_load();
    wait_done(200);
    wait_done(200);
    c = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      c += int'(pwm_out[0]);
    end
    duty = pk(12, 0, 0, 0);
    load = 1'b1;
    step();
    load = 1'b0;
    c += int'(pwm_out[0]);
    got_len = 6;
    while (!last_done && got_len < 40) begin
      step();
      c += int'(pwm_out[0]);
      got_len++;
    end
    chk("reload_old_period_len", got_len, 16);
    chk("reload_old_duty", c, 3);
    prev = pwm_out;
    toggles = 0;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      c += int'(pwm_out[0]);
      if (pwm_out[0] != prev[0]) toggles++;
      prev = pwm_out;
    end
    chk("reload_new_duty", c, 12);
    chk("reload_edges", toggles, 2);

    // Load landing exactly on the boundary tick.
    for (int i = 0; i < 15; i++) step();
    duty = pk(7, 0, 0, 0);
    load = 1'b1;
    step();
    load = 1'b0;
    chk("coincide_is_boundary", last_done, 1);
    count_ch0(16, c);
    chk("coincide_deferred", c, 12);
    count_ch0(16, c);
    chk("coincide_applied", c, 7);

    // Prescaler of 3 clocks, disable mid-period and restart.
    enable = 1'b0;
    step();
    FINAL_VALUE = 2;
    polarity = 4'b0101;
    enable = 1'b1;
    steps_to_done("fv2_first_done", 48);
    steps_to_done("fv2_period", 48);
    for (int i = 0; i < 20; i++) step();
    enable = 1'b0;
    step();
    step();
    chk("disabled_pwm_pol", pwm_out, 4'b0101);
    enable = 1'b1;
    steps_to_done("restart_first_done", 48);

    // Lowering FINAL_VALUE below the running count forces a full wrap.
    enable = 1'b0;
    step();
    FINAL_VALUE = 5;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) step();
    FINAL_VALUE = 1;
    prev = pwm_out;
    toggles = 0;
    for (int i = 0; i < 32000; i++) begin
      step();
      if (pwm_out != prev) toggles++;
      prev = pwm_out;
    end
    chk("fv_wrap_hold", toggles, 0);
    for (int i = 0; i < 800; i++) step();
    enable = 1'b0;
    step();
    FINAL_VALUE = 0;
    enable = 1'b1;

    // Reset mid-period discards a pending load.
    polarity = 4'hF;
    duty = pk(16, 16, 16, 16);
    for (int i = 0; i < 5; i++) step();
    pulse_load();
    step();
    do_reset();
    for (int i = 0; i < 40; i++) step();
    chk("post_rst_pending_dropped", pwm_out, 4'hF);

    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 3) do_reset();
      else if (r < 10) enable = ~enable;
      if (!enable && (r % 7 == 0))
        FINAL_VALUE = TB'($urandom_range(0, 3));
      load = ($urandom_range(0, 15) == 0);
      if (load) begin
        duty = 20'($urandom);
        center_mode = 1'($urandom);
      end
      if ($urandom_range(0, 99) == 0) polarity = 4'($urandom);
      step();
    end
    load = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
